// File: rtl/alu_sequencer.sv
// Handshaked front end for the 4-bit ALU op set: one command at a time, single-cycle
// logic/arithmetic ops, WIDTH-cycle shift-add multiply, registered response channel.
module alu_sequencer #(
  parameter int WIDTH = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic [3:0]         cmd_op,
  input  logic [WIDTH-1:0]   cmd_x,
  input  logic [WIDTH-1:0]   cmd_y,
  input  logic               cmd_cin,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic [2*WIDTH-1:0] rsp_result,
  output logic               rsp_cout,
  output logic               rsp_err,
  output logic               busy
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {S_IDLE, S_MULT, S_RESP} state_t;

  state_t             state_q;
  logic [WIDTH-1:0]   mx_q, my_q;
  logic [2*WIDTH-1:0] acc_q, rsp_result_q;
  logic [CW-1:0]      cnt_q;
  logic               rsp_valid_q, rsp_cout_q, rsp_err_q;

  logic [WIDTH:0]     sum_d, shl_d;
  logic [WIDTH-1:0]   addend_d, alu_res_d;
  logic               alu_cout_d;
  logic [2*WIDTH-1:0] pp_d, acc_d;

  // Single-cycle datapath; sub reuses the adder with an inverted y
  always_comb begin
    addend_d   = (cmd_op == 4'h9) ? ~cmd_y : cmd_y;
    sum_d      = {1'b0, cmd_x} + {1'b0, addend_d} + {{WIDTH{1'b0}}, cmd_cin};
    shl_d      = {1'b0, cmd_x} << cmd_y[1:0];
    alu_res_d  = '0;
    alu_cout_d = 1'b0;
    case (cmd_op)
      4'h0: alu_res_d = cmd_x & cmd_y;
      4'h1: alu_res_d = ~(cmd_x & cmd_y);
      4'h2: alu_res_d = cmd_x | cmd_y;
      4'h3: alu_res_d = ~(cmd_x | cmd_y);
      4'h4: alu_res_d = cmd_x ^ cmd_y;
      4'h5: alu_res_d = ~(cmd_x ^ cmd_y);
      4'h6: alu_res_d = ~cmd_x;
      4'h7: begin
        alu_res_d  = shl_d[WIDTH-1:0];
        alu_cout_d = shl_d[WIDTH];
      end
      4'h8, 4'h9: begin
        alu_res_d  = sum_d[WIDTH-1:0];
        alu_cout_d = sum_d[WIDTH];
      end
      default: begin
        alu_res_d  = '0;
        alu_cout_d = 1'b0;
      end
    endcase
  end

  always_comb begin
    pp_d  = my_q[cnt_q] ? ({{WIDTH{1'b0}}, mx_q} << cnt_q) : '0;
    acc_d = acc_q + pp_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      mx_q         <= '0;
      my_q         <= '0;
      acc_q        <= '0;
      cnt_q        <= '0;
      rsp_result_q <= '0;
      rsp_valid_q  <= 1'b0;
      rsp_cout_q   <= 1'b0;
      rsp_err_q    <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (cmd_valid) begin
            if (cmd_op == 4'hA) begin
              mx_q    <= cmd_x;
              my_q    <= cmd_y;
              acc_q   <= '0;
              cnt_q   <= '0;
              state_q <= S_MULT;
            end else begin
              rsp_result_q <= {{WIDTH{1'b0}}, alu_res_d};
              rsp_cout_q   <= alu_cout_d;
              rsp_err_q    <= (cmd_op > 4'hA);
              rsp_valid_q  <= 1'b1;
              state_q      <= S_RESP;
            end
          end
        end
        S_MULT: begin
          acc_q <= acc_d;
          cnt_q <= cnt_q + CW'(1);
          if (cnt_q == LAST) begin
            rsp_result_q <= acc_d;
            rsp_cout_q   <= 1'b0;
            rsp_err_q    <= 1'b0;
            rsp_valid_q  <= 1'b1;
            state_q      <= S_RESP;
          end
        end
        S_RESP: begin
          if (rsp_ready) begin
            rsp_valid_q <= 1'b0;
            state_q     <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign cmd_ready  = (state_q == S_IDLE);
  assign busy       = (state_q != S_IDLE);
  assign rsp_valid  = rsp_valid_q;
  assign rsp_result = rsp_result_q;
  assign rsp_cout   = rsp_cout_q;
  assign rsp_err    = rsp_err_q;

endmodule

// File: tb/tb_alu_sequencer.sv
// Self-checking bench for alu_sequencer: directed cases plus random ops against an
// arithmetic reference model, including backpressure and reset mid-multiply.
module tb_alu_sequencer;

  localparam int W = 4;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           cmd_valid = 1'b0;
  logic           cmd_ready;
  logic [3:0]     cmd_op = '0;
  logic [W-1:0]   cmd_x = '0;
  logic [W-1:0]   cmd_y = '0;
  logic           cmd_cin = 1'b0;
  logic           rsp_valid;
  logic           rsp_ready = 1'b0;
  logic [2*W-1:0] rsp_result;
  logic           rsp_cout;
  logic           rsp_err;
  logic           busy;

  int n_checks = 0;
  int n_fail   = 0;

  alu_sequencer #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_x(cmd_x), .cmd_y(cmd_y), .cmd_cin(cmd_cin),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result),
    .rsp_cout(rsp_cout), .rsp_err(rsp_err), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference: {err, cout, result[7:0]} straight from the op definitions
  function automatic logic [9:0] model(input int op, input int x, input int y, input int cin);
    int r, c, e, n, t;
    r = 0; c = 0; e = 0;
    case (op)
      0: r = x & y;
      1: r = ~(x & y) & 15;
      2: r = x | y;
      3: r = ~(x | y) & 15;
      4: r = x ^ y;
      5: r = ~(x ^ y) & 15;
      6: r = ~x & 15;
      7: begin
        n = y % 4;
        r = (x << n) & 15;
        c = (n == 0) ? 0 : ((x >> (W - n)) & 1);
      end
      8: begin t = x + y + cin; r = t % 16; c = t / 16; end
      9: begin t = x + (15 - y) + cin; r = t % 16; c = t / 16; end
      10: r = x * y;
      default: e = 1;
    endcase
    return {e[0], c[0], r[7:0]};
  endfunction

  // Issue one command, check latency/response, hold rsp_ready low for 'hold' cycles
  task automatic run_op(input int op, input int x, input int y, input int cin,
                        input int hold, input string tag);
    logic [9:0] exp;
    int lat, waits;
    exp = model(op, x, y, cin);
    @(negedge clk);
    waits = 0;
    while (!cmd_ready && waits < 20) begin @(negedge clk); waits++; end
    chk({tag, "_ready_to"}, 32'(waits < 20), 32'd1);
    cmd_valid = 1'b1;
    cmd_op    = 4'(op);
    cmd_x     = W'(x);
    cmd_y     = W'(y);
    cmd_cin   = cin[0];
    rsp_ready = (hold == 0);
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
    cmd_op    = 4'($urandom_range(0, 15));
    cmd_x     = W'($urandom);
    cmd_y     = W'($urandom);
    lat = 0;
    while (!rsp_valid && lat < 20) begin
      if (op == 10) chk({tag, "_busy"}, 32'(busy), 32'd1);
      @(negedge clk);
      lat++;
    end
    chk({tag, "_lat"}, lat, (op == 10) ? W : 0);
    chk({tag, "_res"}, 32'(rsp_result), 32'(exp[7:0]));
    chk({tag, "_cout"}, 32'(rsp_cout), 32'(exp[8]));
    chk({tag, "_err"}, 32'(rsp_err), 32'(exp[9]));
    for (int i = 0; i < hold; i++) begin
      cmd_valid = 1'b1;
      @(negedge clk);
      chk({tag, "_hold_valid"}, 32'(rsp_valid), 32'd1);
      chk({tag, "_hold_cmdrdy"}, 32'(cmd_ready), 32'd0);
      chk({tag, "_hold_res"}, {rsp_err, rsp_cout, rsp_result}, 32'(exp));
    end
    cmd_valid = 1'b0;
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'($urandom);
    chk({tag, "_post_valid"}, 32'(rsp_valid), 32'd0);
    chk({tag, "_post_cmdrdy"}, 32'(cmd_ready), 32'd1);
  endtask

  initial begin
    int seen;
    #1;
    chk("rst_valid", 32'(rsp_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_out", {rsp_err, rsp_cout, rsp_result}, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_cmdrdy", 32'(cmd_ready), 32'd1);

    run_op(0,  4'b1101, 4'b1110, 0, 0, "and");
    run_op(3,  4'b1001, 4'b0101, 0, 0, "nor");
    run_op(8,  4'b1101, 4'b1110, 1, 0, "add");
    run_op(9,  4'b1001, 4'b0101, 1, 0, "sub_a");
    run_op(9,  4'b1101, 4'b1110, 1, 0, "sub_b");
    run_op(10, 4'b1101, 4'b1110, 0, 0, "mul_a");
    run_op(10, 4'b1001, 4'b0101, 1, 0, "mul_b");
    run_op(7,  4'b1101, 4'b0010, 0, 0, "shift");
    run_op(10, 4'b1111, 4'b1111, 0, 3, "bp_mul");
    run_op(6,  4'b0110, 4'b1010, 0, 3, "bp_not");
    run_op(11, 4'b1111, 4'b1111, 1, 0, "illegal");
    run_op(2,  4'b0101, 4'b0011, 0, 0, "after_ill");

    // Reset two cycles into a multiply abandons it
    @(negedge clk);
    cmd_valid = 1'b1; cmd_op = 4'hA; cmd_x = 4'hF; cmd_y = 4'hF;
    @(negedge clk);
    cmd_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("mrst_out", {busy, rsp_valid, rsp_err, rsp_cout, rsp_result}, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (rsp_valid) seen++;
    end
    chk("mrst_no_rsp", seen, 0);
    run_op(8, 1, 1, 0, 0, "add_after_rst");

    for (int k = 0; k < 60; k++)
      run_op($urandom_range(0, 15), $urandom_range(0, 15), $urandom_range(0, 15),
             $urandom_range(0, 1), $urandom_range(0, 2), "rnd");

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
